// File: rtl/serdes_hdr_err_inject.sv
// 64b/66b sync-header error injector: random, burst and single-shot corruption with block/injection counters.
// Optional build macro SERDES_HDR_ERR_INJECT_DATA_CORRUPT_EN also flips one payload bit on every injected block.
module serdes_hdr_err_inject #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int LFSR_WIDTH  = 32,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   tx_clk,
    input  logic                   tx_rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [HDR_WIDTH-1:0]   in_hdr,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [HDR_WIDTH-1:0]   out_hdr,
    input  logic                   cfg_enable,
    input  logic [1:0]             cfg_mode,
    input  logic [LFSR_WIDTH-1:0]  cfg_threshold,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic [LFSR_WIDTH-1:0]  cfg_seed,
    input  logic                   cfg_seed_load,
    input  logic                   cfg_clear,
    input  logic                   trigger,
    output logic                   err_inj,
    output logic                   busy,
    output logic [31:0]            blk_count,
    output logic [31:0]            inj_count
);

    localparam logic [1:0] MODE_RANDOM = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;
    localparam logic [1:0] MODE_SHOT   = 2'd3;

    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_WIDTH'(32'h8020_0003);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_SHOT  = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
        return {1'b0, v[LFSR_WIDTH-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    // A valid header flips to the invalid code sharing its MSB; invalid codes map onto themselves.
    function automatic logic [HDR_WIDTH-1:0] corrupt_hdr(input logic [HDR_WIDTH-1:0] h);
        return {HDR_WIDTH{h[HDR_WIDTH-1]}};
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BURST_WIDTH-1:0]  r_burst_cnt;
    logic [BURST_WIDTH-1:0]  w_burst_cnt_nxt;
    logic [LFSR_WIDTH-1:0]   r_lfsr;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [HDR_WIDTH-1:0]    r_out_hdr;
    logic                    r_err_inj;
    logic [31:0]             r_blk_count;
    logic [31:0]             r_inj_count;

    logic                    w_fsm_inj;
    logic                    w_rand_inj;
    logic                    w_inj;
    logic [DATA_WIDTH-1:0]   w_data_flip;

    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Losing enable or leaving the owning mode aborts without injecting in that cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_fsm_inj       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_enable && trigger) begin
                    if (cfg_mode == MODE_BURST && cfg_burst_len != '0) begin
                        w_state_nxt     = ST_BURST;
                        w_burst_cnt_nxt = cfg_burst_len;
                    end else if (cfg_mode == MODE_SHOT) begin
                        w_state_nxt = ST_SHOT;
                    end
                end
            end
            ST_BURST: begin
                if (!cfg_enable || cfg_mode != MODE_BURST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_fsm_inj = 1'b1;
                    if (r_burst_cnt == BURST_WIDTH'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt - 1'b1;
                    end
                end
            end
            ST_SHOT: begin
                w_state_nxt = ST_IDLE;
                if (cfg_enable && cfg_mode == MODE_SHOT) begin
                    w_fsm_inj = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Random decision uses the LFSR value before this cycle's advance.
    assign w_rand_inj = (cfg_mode == MODE_RANDOM) && (r_lfsr < cfg_threshold);
    assign w_inj      = cfg_enable && (w_rand_inj || w_fsm_inj);

    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            r_lfsr <= '1;
        end else if (cfg_seed_load) begin
            r_lfsr <= (cfg_seed == '0) ? LFSR_WIDTH'(1) : cfg_seed;
        end else if (cfg_enable) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

`ifdef SERDES_HDR_ERR_INJECT_DATA_CORRUPT_EN
    always_comb begin
        w_data_flip = '0;
        if (w_inj) begin
            w_data_flip[r_lfsr[5:0]] = 1'b1;
        end
    end
`else
    assign w_data_flip = '0;
`endif

    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            r_out_data <= '0;
            r_out_hdr  <= '0;
            r_err_inj  <= 1'b0;
        end else begin
            r_out_data <= in_data ^ w_data_flip;
            r_out_hdr  <= w_inj ? corrupt_hdr(in_hdr) : in_hdr;
            r_err_inj  <= w_inj;
        end
    end

    // Injections are counted off the registered flag so a clear in the same cycle wins.
    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            r_blk_count <= '0;
            r_inj_count <= '0;
        end else if (cfg_clear) begin
            r_blk_count <= '0;
            r_inj_count <= '0;
        end else begin
            r_blk_count <= sat_inc(r_blk_count);
            if (r_err_inj) begin
                r_inj_count <= sat_inc(r_inj_count);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_hdr   = r_out_hdr;
    assign err_inj   = r_err_inj;
    assign busy      = (r_state != ST_IDLE);
    assign blk_count = r_blk_count;
    assign inj_count = r_inj_count;

endmodule

// File: tb/tb_serdes_hdr_err_inject.sv
// Scoreboard bench for serdes_hdr_err_inject: each driven block pushes its expected output, popped one edge later.
module tb_serdes_hdr_err_inject;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_RAND  = 2'd1;
    localparam logic [1:0] M_BURST = 2'd2;
    localparam logic [1:0] M_SHOT  = 2'd3;
    localparam logic [31:0] TAPS = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b0;
    logic [63:0] in_data = '0;
    logic [1:0]  in_hdr = 2'b10;
    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic        cfg_enable = 1'b0;
    logic [1:0]  cfg_mode = M_OFF;
    logic [31:0] cfg_threshold = '0;
    logic [7:0]  cfg_burst_len = '0;
    logic [31:0] cfg_seed = '0;
    logic        cfg_seed_load = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        trigger = 1'b0;
    logic        err_inj;
    logic        busy;
    logic [31:0] blk_count;
    logic [31:0] inj_count;

    typedef struct packed {
        logic [1:0]  hdr;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_lfsr = 32'hFFFF_FFFF;

    serdes_hdr_err_inject dut (
        .tx_clk        (tx_clk),
        .tx_rst        (tx_rst),
        .in_data       (in_data),
        .in_hdr        (in_hdr),
        .out_data      (out_data),
        .out_hdr       (out_hdr),
        .cfg_enable    (cfg_enable),
        .cfg_mode      (cfg_mode),
        .cfg_threshold (cfg_threshold),
        .cfg_burst_len (cfg_burst_len),
        .cfg_seed      (cfg_seed),
        .cfg_seed_load (cfg_seed_load),
        .cfg_clear     (cfg_clear),
        .trigger       (trigger),
        .err_inj       (err_inj),
        .busy          (busy),
        .blk_count     (blk_count),
        .inj_count     (inj_count)
    );

    always #5 tx_clk = ~tx_clk;

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ TAPS;
        return r;
    endfunction

    // Drive one block, record what it must look like on the output, advance the LFSR model past the edge.
    task automatic blk(input logic [1:0] h, input logic [63:0] d, input logic trig, input logic inj);
        exp_t e;
        in_hdr  = h;
        in_data = d;
        trigger = trig;
        e.hdr   = inj ? {h[1], h[1]} : h;
        e.err   = inj;
        e.data  = d;
`ifdef SERDES_HDR_ERR_INJECT_DATA_CORRUPT_EN
        if (inj) e.data[m_lfsr[5:0]] = ~e.data[m_lfsr[5:0]];
`endif
        exp_q.push_back(e);
        @(posedge tx_clk);
        if (!tx_rst) m_lfsr = 32'hFFFF_FFFF;
        else if (cfg_seed_load) m_lfsr = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
        else if (cfg_enable) m_lfsr = lfsr_adv(m_lfsr);
        #1;
        trigger       = 1'b0;
        cfg_seed_load = 1'b0;
        cfg_clear     = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        tx_rst = 1'b0; in_hdr = 2'b10; in_data = '1; cfg_enable = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        n_chk++; if (out_hdr !== 2'b00) begin n_err++; $display("FAIL reset_hdr got=%b want=00", out_hdr); end
        n_chk++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset_data got=%h want=0", out_data); end
        n_chk++; if (blk_count !== 32'd0 || inj_count !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt blk=%0d inj=%0d want 0/0", blk_count, inj_count); end
        n_chk++; if (err_inj !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_flags err=%b busy=%b want 0/0", err_inj, busy); end
        tx_rst = 1'b1;
        m_lfsr = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            blk(2'b10, '1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL post_reset[%0d] hdr=%b err=%b data=%h want hdr=%b err=%b data=%h",
                                  i, out_hdr, err_inj, out_data, e.hdr, e.err, e.data);
            end
        end
        n_chk++; if (blk_count !== 32'd4) begin n_err++; $display("FAIL post_reset_blk got=%0d want=4", blk_count); end
    endtask

    task automatic test_random();
        exp_t        e;
        int          n_inj;
        logic        inj_e;
        logic [31:0] thr;
        thr = 32'h2A3D_70A4;
        cfg_enable = 1'b0; cfg_mode = M_RAND; cfg_threshold = thr; cfg_clear = 1'b1;
        blk(2'b10, 64'd0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_chk++; if ({out_hdr, err_inj} !== {e.hdr, e.err}) begin
            n_err++; $display("FAIL rand_pre hdr=%b err=%b want hdr=%b err=%b", out_hdr, err_inj, e.hdr, e.err); end
        cfg_enable = 1'b1;
        n_inj = 0;
        for (int i = 0; i < 10000; i++) begin
            inj_e = (m_lfsr < thr);
            if (inj_e) n_inj++;
            blk(2'b10, {$urandom, $urandom}, 1'b0, inj_e);
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL rand_blk[%0d] hdr=%b err=%b data=%h want hdr=%b err=%b data=%h",
                                  i, out_hdr, err_inj, out_data, e.hdr, e.err, e.data);
            end
        end
        n_chk++; if (blk_count !== 32'd10000) begin n_err++; $display("FAIL rand_blk_count got=%0d want=10000", blk_count); end
        cfg_enable = 1'b0;
        blk(2'b10, 64'd0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_chk++; if ({out_hdr, err_inj} !== {e.hdr, e.err}) begin
            n_err++; $display("FAIL rand_post hdr=%b err=%b want hdr=%b err=%b", out_hdr, err_inj, e.hdr, e.err); end
        n_chk++; if (inj_count !== 32'(n_inj)) begin n_err++; $display("FAIL rand_inj_count got=%0d want=%0d", inj_count, n_inj); end
        n_chk++; if (inj_count < 32'd1500 || inj_count > 32'd1800) begin
            n_err++; $display("FAIL rand_rate got=%0d want 1500..1800", inj_count); end
    endtask

    task automatic test_burst();
        exp_t e;
        int   nbusy, win, bad;
        logic lost;
        cfg_enable = 1'b1; cfg_mode = M_BURST; cfg_burst_len = 8'd66; cfg_clear = 1'b1;
        blk(2'b10, 64'd0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_chk++; if ({out_hdr, err_inj} !== {e.hdr, e.err}) begin
            n_err++; $display("FAIL burst_pre hdr=%b err=%b want hdr=%b err=%b", out_hdr, err_inj, e.hdr, e.err); end
        nbusy = 0; win = 0; bad = 0; lost = 1'b0;
        for (int i = -1; i < 70; i++) begin
            blk(2'b10, {$urandom, $urandom}, (i == -1), (i >= 0 && i < 66));
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL burst_blk[%0d] hdr=%b err=%b want hdr=%b err=%b", i, out_hdr, err_inj, e.hdr, e.err);
            end
            if (busy) nbusy++;
            win++;
            if (out_hdr == 2'b00 || out_hdr == 2'b11) bad++;
            if (bad >= 16) lost = 1'b1;
            if (win == 64) begin win = 0; bad = 0; end
        end
        n_chk++; if (nbusy != 66) begin n_err++; $display("FAIL burst_busy_cycles got=%0d want=66", nbusy); end
        n_chk++; if (inj_count !== 32'd66) begin n_err++; $display("FAIL burst_inj_count got=%0d want=66", inj_count); end
        n_chk++; if (lost !== 1'b1) begin n_err++; $display("FAIL burst_block_lock got_lost=%b want=1", lost); end
    endtask

    task automatic test_burst_edge();
        exp_t e;
        cfg_enable = 1'b1; cfg_mode = M_BURST; cfg_burst_len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            blk(2'b01, {$urandom, $urandom}, (i == 0), 1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, busy} !== {e.hdr, e.err, 1'b0}) begin
                n_err++; $display("FAIL len0[%0d] hdr=%b err=%b busy=%b want hdr=%b err=%b busy=0", i, out_hdr, err_inj, busy, e.hdr, e.err);
            end
        end
        cfg_burst_len = 8'd66; cfg_clear = 1'b1;
        blk(2'b01, 64'd0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = -1; i < 80; i++) begin
            blk(2'b01, {$urandom, $urandom}, (i == -1 || i == 20), (i >= 0 && i < 66));
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL retrig[%0d] hdr=%b err=%b want hdr=%b err=%b", i, out_hdr, err_inj, e.hdr, e.err);
            end
        end
        n_chk++; if (inj_count !== 32'd66 || busy !== 1'b0) begin
            n_err++; $display("FAIL retrig_total inj=%0d busy=%b want 66/0", inj_count, busy); end
        cfg_clear = 1'b1;
        blk(2'b10, 64'd0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = -1; i < 14; i++) begin
            if (i == 10) cfg_enable = 1'b0;
            blk(2'b10, {$urandom, $urandom}, (i == -1), (i >= 0 && i < 10));
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL abort[%0d] hdr=%b err=%b want hdr=%b err=%b", i, out_hdr, err_inj, e.hdr, e.err);
            end
        end
        n_chk++; if (inj_count !== 32'd10 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_total inj=%0d busy=%b want 10/0", inj_count, busy); end
        cfg_enable = 1'b1;
    endtask

    task automatic test_shot_clear();
        exp_t e;
        cfg_enable = 1'b1; cfg_mode = M_SHOT; cfg_clear = 1'b1;
        blk(2'b10, 64'd0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                blk(2'b10, {$urandom, $urandom}, (i == 0), (i == 1));
                e = exp_q.pop_front();
                n_chk++;
                if ({out_hdr, err_inj, out_data, busy} !== {e.hdr, e.err, e.data, (i == 0)}) begin
                    n_err++; $display("FAIL shot[%0d][%0d] hdr=%b err=%b busy=%b want hdr=%b err=%b busy=%b",
                                      k, i, out_hdr, err_inj, busy, e.hdr, e.err, (i == 0));
                end
            end
        end
        n_chk++; if (inj_count !== 32'd3) begin n_err++; $display("FAIL shot_count got=%0d want=3", inj_count); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) cfg_clear = 1'b1;
            blk(2'b10, {$urandom, $urandom}, (i == 0), (i == 1));
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL clr_shot[%0d] hdr=%b err=%b want hdr=%b err=%b", i, out_hdr, err_inj, e.hdr, e.err);
            end
            if (i >= 2) begin
                n_chk++;
                if (inj_count !== 32'd0) begin n_err++; $display("FAIL clear_prio[%0d] inj=%0d want=0", i, inj_count); end
            end
        end
    endtask

    task automatic test_seed_reset();
        exp_t        e;
        int          n_late;
        logic        inj_e;
        logic [31:0] thr;
        thr = 32'h8000_0000;
        cfg_enable = 1'b1; cfg_mode = M_OFF; cfg_seed = 32'd0; cfg_seed_load = 1'b1;
        blk(2'b10, 64'd0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        cfg_mode = M_RAND; cfg_threshold = thr; n_late = 0;
        for (int i = 0; i < 200; i++) begin
            inj_e = (m_lfsr < thr);
            blk(2'b10, {$urandom, $urandom}, 1'b0, inj_e);
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, out_data} !== {e.hdr, e.err, e.data}) begin
                n_err++; $display("FAIL seed0[%0d] hdr=%b err=%b want hdr=%b err=%b", i, out_hdr, err_inj, e.hdr, e.err);
            end
            if (i >= 100 && err_inj === 1'b1) n_late++;
        end
        n_chk++; if (n_late == 0) begin n_err++; $display("FAIL seed0_alive late_inj=%0d want >0", n_late); end
        cfg_mode = M_BURST; cfg_burst_len = 8'd66;
        for (int i = -1; i < 10; i++) begin
            blk(2'b10, {$urandom, $urandom}, (i == -1), (i >= 0));
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj} !== {e.hdr, e.err}) begin
                n_err++; $display("FAIL pre_rst[%0d] hdr=%b err=%b want hdr=%b err=%b", i, out_hdr, err_inj, e.hdr, e.err);
            end
        end
        tx_rst = 1'b0;
        #1;
        n_chk++; if ({busy, err_inj, out_hdr} !== 4'b0000) begin
            n_err++; $display("FAIL midrst_flags busy=%b err=%b hdr=%b want 0/0/00", busy, err_inj, out_hdr); end
        n_chk++; if (blk_count !== 32'd0 || inj_count !== 32'd0) begin
            n_err++; $display("FAIL midrst_cnt blk=%0d inj=%0d want 0/0", blk_count, inj_count); end
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b1;
        m_lfsr = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            blk(2'b10, {$urandom, $urandom}, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if ({out_hdr, err_inj, busy} !== {e.hdr, e.err, 1'b0}) begin
                n_err++; $display("FAIL no_resume[%0d] hdr=%b err=%b busy=%b want hdr=%b err=0 busy=0", i, out_hdr, err_inj, busy, e.hdr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_burst();
        test_burst_edge();
        test_shot_clear();
        test_seed_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
